shift_seq_ctrl: RTL and testbench



---
 rtl/shift_seq_ctrl_if.sv | 24 ++
 rtl/shift_seq_ctrl.sv | 92 +++++++++
 tb/tb_shift_seq_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/shift_seq_ctrl_if.sv
// shift_seq_ctrl_if: request/response bundle between issue, the shift sequencer and writeback
interface shift_seq_ctrl_if;
  logic v_i;
  logic ready_o;
  logic [1:0] shift_type_i;
  logic [15:0] rd_data_i;
  logic [15:0] rm_data_i;
  logic carry_i;
  logic v_o;
  logic yumi_i;
  logic [15:0] data_shifted_o;
  logic negative_o;
  logic zero_o;
  logic carry_o;
  logic [15:0] ops_cnt_o;
  modport master (
    output v_i, shift_type_i, rd_data_i, rm_data_i, carry_i, yumi_i,
    input ready_o, v_o, data_shifted_o, negative_o, zero_o, carry_o, ops_cnt_o
  );
  modport slave (
    input v_i, shift_type_i, rd_data_i, rm_data_i, carry_i, yumi_i,
    output ready_o, v_o, data_shifted_o, negative_o, zero_o, carry_o, ops_cnt_o
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multi-cycle Thumb LSLS/LSRS/ASRS/RORS sequencer, STEP bits per cycle; SHIFT_SEQ_PERF_CNT_EN adds an op counter
module shift_seq_ctrl #(
  parameter int STEP = 4
) (
  input logic clk_i,
  input logic reset_n_i,
  shift_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] data_q, data_d, sh_d;
  logic [1:0] type_q, type_d;
  logic [4:0] rem_q, rem_d, amt, k;
  logic carry_q, carry_d, sh_c, neg_q, zero_q;
  logic [7:0] a;
  logic unused_rm;
  assign a = bus.rm_data_i[7:0];
  assign unused_rm = ^bus.rm_data_i[15:8];
  assign amt = bus.shift_type_i == 2'b11 ? (a == 8'd0 ? 5'd0 : a[3:0] == 4'd0 ? 5'd16 : {1'b0, a[3:0]})
             : bus.shift_type_i == 2'b10 ? (a > 8'd16 ? 5'd16 : a[4:0])
             : (a > 8'd17 ? 5'd17 : a[4:0]);
  assign k = rem_q < 5'(STEP) ? rem_q : 5'(STEP);
  always_comb begin
    sh_d = data_q;
    sh_c = carry_q;
    for (int i = 1; i <= STEP; i++)
      if (k == 5'(i)) begin
        sh_d = type_q == 2'b00 ? data_q << i
             : type_q == 2'b01 ? data_q >> i
             : type_q == 2'b10 ? 16'($signed(data_q) >>> i)
             : (data_q >> i) | (data_q << (16 - i));
        sh_c = type_q == 2'b00 ? data_q[4'(16 - i)] : data_q[4'(i - 1)];
      end
  end
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    carry_d = carry_q;
    type_d = type_q;
    rem_d = rem_q;
    unique case (state_q)
      IDLE: if (bus.v_i) begin
        data_d = bus.rd_data_i;
        carry_d = bus.carry_i;
        type_d = bus.shift_type_i;
        rem_d = amt;
        state_d = amt == 5'd0 ? DONE : SHIFT;
      end
      SHIFT: begin
        data_d = sh_d;
        carry_d = sh_c;
        rem_d = rem_q - k;
        state_d = rem_q == k ? DONE : SHIFT;
      end
      DONE: state_d = bus.yumi_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i)
    if (!reset_n_i) begin
      state_q <= IDLE;
      data_q <= '0;
      carry_q <= 1'b0;
      type_q <= 2'b00;
      rem_q <= '0;
      neg_q <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      carry_q <= carry_d;
      type_q <= type_d;
      rem_q <= rem_d;
      neg_q <= data_d[15];
      zero_q <= data_d == 16'd0;
    end
  assign bus.ready_o = state_q == IDLE;
  assign bus.v_o = state_q == DONE;
  assign bus.data_shifted_o = data_q;
  assign bus.negative_o = neg_q;
  assign bus.zero_o = zero_q;
  assign bus.carry_o = carry_q;
`ifdef SHIFT_SEQ_PERF_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk_i)
    if (!reset_n_i) cnt_q <= '0;
    else if (bus.v_o && bus.yumi_i && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  assign bus.ops_cnt_o = cnt_q;
`else
  assign bus.ops_cnt_o = 16'h0000;
`endif
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed vector table, corner sequences and randomized ops against a reference model
module tb_shift_seq_ctrl;
  localparam int STEP = 4;
  typedef struct {
    logic [1:0] t;
    logic [15:0] d;
    logic [15:0] rm;
    logic cin;
    logic [15:0] er;
    logic ec;
    int elat;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int done_ops = 0;
  vec_t vecs[11];
  shift_seq_ctrl_if bus();
  shift_seq_ctrl #(.STEP(STEP)) dut (.clk_i(clk), .reset_n_i(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic drive_junk();
    bus.v_i = 1'($urandom);
    bus.shift_type_i = 2'($urandom);
    bus.rd_data_i = 16'($urandom);
    bus.rm_data_i = 16'($urandom);
    bus.carry_i = 1'($urandom);
  endtask
  function automatic logic [15:0] exp_cnt();
`ifdef SHIFT_SEQ_PERF_CNT_EN
    return done_ops > 65535 ? 16'hFFFF : 16'(done_ops);
`else
    return 16'h0000;
`endif
  endfunction
  function automatic void model(input logic [1:0] t, input logic [15:0] d, input logic [15:0] rm,
                                input logic cin, output logic [15:0] r, output logic c, output int lat);
    int a, e, q;
    logic [63:0] w;
    logic signed [63:0] s;
    a = int'(rm[7:0]);
    e = 0;
    r = d;
    c = cin;
    if (a != 0)
      case (t)
        2'b00: begin w = 64'(d) << a; r = w[15:0]; c = w[16]; e = a > 17 ? 17 : a; end
        2'b01: begin w = {32'b0, d, 16'b0} >> a; r = w[31:16]; c = w[15]; e = a > 17 ? 17 : a; end
        2'b10: begin s = {{32{d[15]}}, d, 16'b0}; s = s >>> a; r = s[31:16]; c = s[15]; e = a > 16 ? 16 : a; end
        default: begin
          q = a % 16;
          r = q == 0 ? d : 16'((d >> q) | (d << (16 - q)));
          c = r[15];
          e = q == 0 ? 16 : q;
        end
      endcase
    lat = (e + STEP - 1) / STEP + 1;
  endfunction
  task automatic run_op(input logic [1:0] t, input logic [15:0] d, input logic [15:0] rm, input logic cin,
                        input logic [15:0] er, input logic ec, input int elat, input int hold);
    int lat;
    @(negedge clk);
    check("ready_idle", 32'(bus.ready_o), 1);
    bus.v_i = 1'b1;
    bus.shift_type_i = t;
    bus.rd_data_i = d;
    bus.rm_data_i = rm;
    bus.carry_i = cin;
    @(negedge clk);
    lat = 1;
    drive_junk();
    while (!bus.v_o && lat < 40) begin
      @(negedge clk);
      drive_junk();
      lat++;
    end
    check("latency", 32'(lat), 32'(elat));
    for (int i = 0; i <= hold; i++) begin
      check("data", 32'(bus.data_shifted_o), 32'(er));
      check("negative", 32'(bus.negative_o), 32'(er[15]));
      check("zero", 32'(bus.zero_o), 32'(er == 16'd0));
      check("carry", 32'(bus.carry_o), 32'(ec));
      check("ready_busy", 32'(bus.ready_o), 0);
      check("v_held", 32'(bus.v_o), 1);
      if (i < hold) begin
        @(negedge clk);
        drive_junk();
      end
    end
    bus.v_i = 1'b0;
    bus.yumi_i = 1'b1;
    @(negedge clk);
    bus.yumi_i = 1'b0;
    done_ops++;
    check("v_after_yumi", 32'(bus.v_o), 0);
    check("ops_cnt", 32'(bus.ops_cnt_o), 32'(exp_cnt()));
  endtask
  task automatic check_reset_state();
    check("rst_ready", 32'(bus.ready_o), 1);
    check("rst_v", 32'(bus.v_o), 0);
    check("rst_data", 32'(bus.data_shifted_o), 0);
    check("rst_neg", 32'(bus.negative_o), 0);
    check("rst_zero", 32'(bus.zero_o), 1);
    check("rst_carry", 32'(bus.carry_o), 0);
    check("rst_cnt", 32'(bus.ops_cnt_o), 0);
  endtask
  initial begin
    logic [1:0] t;
    logic [15:0] d, rm, er;
    logic cin, ec;
    int lat;
    vecs[0] = '{2'b00, 16'h8001, 16'h0001, 1'b0, 16'h0002, 1'b1, 2};
    vecs[1] = '{2'b10, 16'h8000, 16'h0014, 1'b0, 16'hFFFF, 1'b1, 5};
    vecs[2] = '{2'b11, 16'h1238, 16'h0024, 1'b0, 16'h8123, 1'b1, 2};
    vecs[3] = '{2'b11, 16'h1234, 16'h0010, 1'b1, 16'h1234, 1'b0, 5};
    vecs[4] = '{2'b01, 16'h00FF, 16'h0000, 1'b1, 16'h00FF, 1'b1, 1};
    vecs[5] = '{2'b00, 16'h0001, 16'h0011, 1'b1, 16'h0000, 1'b0, 6};
    vecs[6] = '{2'b00, 16'h0001, 16'h0010, 1'b0, 16'h0000, 1'b1, 5};
    vecs[7] = '{2'b01, 16'h8000, 16'h0010, 1'b0, 16'h0000, 1'b1, 5};
    vecs[8] = '{2'b10, 16'h7FFF, 16'h00C8, 1'b1, 16'h0000, 1'b0, 5};
    vecs[9] = '{2'b01, 16'hF0F0, 16'hAB04, 1'b1, 16'h0F0F, 1'b0, 2};
    vecs[10] = '{2'b01, 16'h00FF, 16'hFF00, 1'b0, 16'h00FF, 1'b0, 1};
    bus.v_i = 1'b0;
    bus.yumi_i = 1'b0;
    bus.shift_type_i = 2'b00;
    bus.rd_data_i = 16'h0;
    bus.rm_data_i = 16'h0;
    bus.carry_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    foreach (vecs[i])
      run_op(vecs[i].t, vecs[i].d, vecs[i].rm, vecs[i].cin, vecs[i].er, vecs[i].ec, vecs[i].elat, 0);
    run_op(2'b11, 16'h1238, 16'h0024, 1'b0, 16'h8123, 1'b1, 2, 10);
    @(negedge clk);
    bus.v_i = 1'b1;
    bus.shift_type_i = 2'b00;
    bus.rd_data_i = 16'h0001;
    bus.rm_data_i = 16'h0011;
    @(negedge clk);
    bus.v_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    done_ops = 0;
    check_reset_state();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_v_after_reset", 32'(bus.v_o), 0);
    end
    for (int i = 0; i < 150; i++) begin
      t = 2'($urandom);
      d = 16'($urandom);
      rm = $urandom_range(0, 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      cin = 1'($urandom);
      model(t, d, rm, cin, er, ec, lat);
      run_op(t, d, rm, cin, er, ec, lat, $urandom_range(0, 2));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
